// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared constants and helpers for the T-cell up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Largest legal count value; the up-count wrap point and down-count reload.
    function automatic int unsigned term_value(input int unsigned modulus);
        return modulus - 32'd1;
    endfunction

    function automatic bit params_ok(input int unsigned width, input longint unsigned modulus);
        return (width >= 1) && (modulus >= 2) && (modulus <= (64'd1 << width));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tff_cell.sv
`default_nettype none
// ============================================================================
// Module      : tff_cell
// Description : Single toggle flip-flop bit with asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/tff_counter.sv
`default_nettype none
// ============================================================================
// Module      : tff_counter
// Description : Modulo-MODULUS up/down counter built from T cells, with load,
//               cascade-ready terminal count and registered wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tff_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    generate
        if (!params_ok(WIDTH, MODULUS)) begin : g_param_check
            $fatal(1, "tff_counter: MODULUS must lie in 2..2**WIDTH and WIDTH >= 1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_term = WIDTH'(term_value(MODULUS));

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_t;
    logic             w_at_top;
    logic             w_at_zero;
    logic             w_tc;
    logic             r_wrap;

    assign w_at_top  = (w_q == c_term);
    assign w_at_zero = (w_q == '0);

    always_comb begin
        w_next = w_q;
        if (load) begin
            // Out-of-range load values saturate so q never leaves 0..MODULUS-1.
            w_next = (d > c_term) ? c_term : d;
        end else if (en) begin
            if (up == CNT_UP) begin
                w_next = w_at_top ? '0 : w_q + 1'b1;
            end else begin
                w_next = w_at_zero ? c_term : w_q - 1'b1;
            end
        end
    end

    assign w_t = w_q ^ w_next;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            tff_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .t     (w_t[i]),
                .q     (w_q[i])
            );
        end
    endgenerate

    assign w_tc = en & ~load & ((up == CNT_UP) ? w_at_top : w_at_zero);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_tc;
        end
    end

    assign q    = w_q;
    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_tff_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tff_counter
// Description : Directed scoreboard bench for tff_counter (WIDTH 4, MODULUS 10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tff_counter;

    typedef struct {
        string      nm;
        logic [7:0] q;
        logic       tc;
        logic       wrap;
        bit         cas;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] d = 4'd0;
    logic [3:0] q;
    logic       tc;
    logic       wrap;

    logic       cas_reset = 1'b0;
    logic       cas_en = 1'b1;
    logic [3:0] lo_q;
    logic       lo_tc;
    logic       lo_wrap;
    logic [3:0] hi_q;
    logic       hi_tc;
    logic       hi_wrap;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
        .q(q), .tc(tc), .wrap(wrap)
    );

    tff_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .reset(cas_reset), .en(cas_en), .up(1'b1), .load(1'b0), .d(4'd0),
        .q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
    );

    tff_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .reset(cas_reset), .en(lo_tc), .up(1'b1), .load(1'b0), .d(4'd0),
        .q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
    );

    // Monitor: samples 4 time units after each clock edge, away from posedge.
    initial begin
        exp_t       e;
        logic [7:0] aq;
        logic       atc;
        logic       aw;
        forever begin
            @(clk);
            #4;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.cas) begin
                    aq = {hi_q, lo_q}; atc = hi_tc; aw = hi_wrap;
                end else begin
                    aq = {4'd0, q}; atc = tc; aw = wrap;
                end
                n_cmp++;
                if (aq !== e.q || atc !== e.tc || aw !== e.wrap) begin
                    n_fail++;
                    $display("FAIL %s: got q=%h tc=%b wrap=%b, want q=%h tc=%b wrap=%b",
                             e.nm, aq, atc, aw, e.q, e.tc, e.wrap);
                end
            end
        end
    end

    task automatic push(input logic [7:0] eq, input logic etc, input logic ew,
                        input string nm, input bit cas);
        exp_t e;
        e.nm = nm; e.q = eq; e.tc = etc; e.wrap = ew; e.cas = cas;
        sb.push_back(e);
    endtask

    // Drive after a rising edge; expectation is the state produced by that edge.
    task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] dv, input logic [3:0] eq, input logic etc,
                       input logic ew, input string nm);
        @(posedge clk);
        #1;
        reset = r; en = e; up = u; load = l; d = dv;
        push({4'd0, eq}, etc, ew, nm, 1'b0);
    endtask

    // Drive between edges (after the falling edge) to check asynchronous behaviour.
    task automatic mid(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] dv, input logic [3:0] eq, input logic etc,
                       input logic ew, input string nm);
        @(negedge clk);
        #1;
        reset = r; en = e; up = u; load = l; d = dv;
        push({4'd0, eq}, etc, ew, nm, 1'b0);
    endtask

    logic [3:0] up_q  [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
    logic       up_tc [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       up_w  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int hi_wraps;
        // Reset and up-count
        mid(0, 0, 1, 0, 4'd0, 4'd0, 0, 0, "rst_async");
        cyc(0, 0, 1, 0, 4'd0, 4'd0, 0, 0, "rst_hold");
        cyc(1, 1, 1, 0, 4'd0, 4'd0, 0, 0, "release");
        for (int i = 0; i < 11; i++) begin
            cyc(1, 1, 1, 0, 4'd0, up_q[i], up_tc[i], up_w[i], "up_seq");
        end
        // Down-count underflow
        cyc(1, 0, 1, 1, 4'd2,  4'd2, 0, 0, "up_q2_load2");
        cyc(1, 1, 0, 0, 4'd0,  4'd2, 0, 0, "dn_q2");
        cyc(1, 1, 0, 0, 4'd0,  4'd1, 0, 0, "dn_q1");
        cyc(1, 1, 0, 0, 4'd0,  4'd0, 1, 0, "dn_q0_tc");
        cyc(1, 1, 0, 0, 4'd0,  4'd9, 0, 1, "dn_wrap9");
        // Load priority and clamp
        cyc(1, 1, 1, 1, 4'd5,  4'd8, 0, 0, "dn_q8_load_en");
        cyc(1, 0, 1, 1, 4'd13, 4'd5, 0, 0, "load5");
        cyc(1, 0, 1, 0, 4'd0,  4'd9, 0, 0, "clamp9");
        cyc(1, 0, 1, 0, 4'd0,  4'd9, 0, 0, "hold1");
        cyc(1, 0, 1, 0, 4'd0,  4'd9, 0, 0, "hold2");
        // Direction flip at boundary
        cyc(1, 1, 1, 0, 4'd0,  4'd9, 1, 0, "hold3_tc_up");
        mid(1, 1, 0, 0, 4'd0,  4'd9, 0, 0, "flip_tc0");
        cyc(1, 1, 1, 0, 4'd0,  4'd8, 0, 0, "flip_q8_nowrap");
        cyc(1, 1, 1, 0, 4'd0,  4'd9, 1, 0, "up9");
        cyc(1, 1, 1, 0, 4'd0,  4'd0, 0, 1, "up_wrap0");
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 1, 1, 0, 4'd0, 4'(i), 0, 0, "up_run");
        end
        // Reset mid-count
        cyc(1, 1, 1, 0, 4'd0,  4'd6, 0, 0, "q6");
        mid(0, 1, 1, 0, 4'd0,  4'd0, 0, 0, "rst_mid");
        cyc(1, 1, 1, 0, 4'd0,  4'd0, 0, 0, "rst_release");
        cyc(1, 1, 1, 0, 4'd0,  4'd1, 0, 0, "first_edge");
        cyc(1, 0, 1, 0, 4'd0,  4'd2, 0, 0, "after_first");

        // Cascade: two decades, 100 clocks from 00 roll back to 00
        @(posedge clk);
        #1;
        cas_reset = 1'b1;
        push(8'h00, 0, 0, "cas_start", 1'b1);
        hi_wraps = 0;
        for (int k = 1; k <= 101; k++) begin
            @(posedge clk);
            #1;
            if (hi_wrap === 1'b1) hi_wraps++;
            if (k == 50)  push(8'h50, 0, 0, "cas_50", 1'b1);
            if (k == 99)  push(8'h99, 1, 0, "cas_99", 1'b1);
            if (k == 100) push(8'h00, 0, 1, "cas_rollover", 1'b1);
            if (k == 101) push(8'h01, 0, 0, "cas_101", 1'b1);
        end
        n_cmp++;
        if (hi_wraps != 1) begin
            n_fail++;
            $display("FAIL cas_hi_wrap_count: got %0d, want 1", hi_wraps);
        end

        @(posedge clk);
        #6;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish by 100000, want finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/tff_counter.md
# tff_counter

Parametrised synchronous up/down counter built from a row of T flip-flop cells, the multi-bit successor to the single toggle flip-flop. Each bit's toggle enable is computed so the register steps by ±1 modulo MODULUS, with parallel load, count enable and terminal-count/wrap flags. It is used as the general event, divider and sequence counter in the lab designs.

## Interface
- WIDTH, 4, counter width in bits; at least 1.
- MODULUS, 2**WIDTH, count range is 0..MODULUS-1; legal range is 2..2**WIDTH.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  synchronous parallel load; it takes priority over en.
- d  in  WIDTH  load value.
- q  out  WIDTH  current count.
- tc  out  1  combinational terminal count.
- wrap  out  1  registered one-cycle pulse after a modulus wrap.

## Operation
- Next-state priority per rising edge:
  - load = 1: q <= d. If d ≥ MODULUS, then q <= MODULUS-1 (saturating clamp).
  - Otherwise, en = 1 and up = 1: q <= (q == MODULUS-1) ? 0 : q+1.
  - Otherwise, en = 1 and up = 0: q <= (q == 0) ? MODULUS-1 : q-1.
  - Otherwise: q holds.
- Datapath form:
  - toggle vector t = q ^ q_next is fed to WIDTH T cells, each with q_i <= q_i ^ t_i.
  - There is no direct D path for q. Load is also expressed as toggles.
- tc = en & ~load & (up ? q == MODULUS-1 : q == 0).
  - Purely combinational.
  - Cascade-ready: it chains to the next counter's en.
- wrap is registered: wrap <= tc.
  - High for exactly the cycle following the edge on which q wrapped.
- Direction change takes effect on the very next edge; there is no pipeline.
- Arithmetic is unsigned, WIDTH bits.
  - q is never outside 0..MODULUS-1 after reset or load.
  - When MODULUS = 2**WIDTH, wrap is natural overflow/underflow.
- Reset (reset = 0): q = 0 and wrap = 0 immediately, regardless of clk.
  - tc then reflects q = 0 (high only if en & ~load & ~up).
- Reset during an active count or load: the operation is abandoned with no residual state. The first edge after release acts on q = 0.

## Timing
- Latency: one clock from a load/en/up sample to the new q.
- wrap lags tc by one clock.
- tc is combinational from en, load, up and q; the path is the compare logic only.
- reset assertion is asynchronous. Release is sampled at the next rising edge.
  - Release timing relative to clk is the integrator's responsibility.
- Simultaneous load & en: load wins, tc = 0, and no wrap pulse follows.
- Throughput: one step per clock, so en may stay high continuously.

## Structure
- Sub-module tff_cell holds one bit:
  - ports q, t, clk, reset.
  - asynchronous active-low reset to 0; q <= q ^ t.
  - instantiated WIDTH times in a generate loop.
- Shared package/header (counter_pkg) holds:
  - helper constant function for the MODULUS-1 terminal value.
  - elaboration check: MODULUS in 2..2**WIDTH and WIDTH ≥ 1, else fatal.
  - direction encoding constants CNT_UP = 1, CNT_DN = 0.
- Top level contains only the next-value mux, the toggle-vector XOR, the tc compare and the wrap register.

## Test plan
All scenarios use WIDTH = 4, MODULUS = 10.
- Reset and up-count:
  - Hold reset = 0 mid-cycle: q = 0 and wrap = 0 with no clock edge.
  - Release, then en = 1, up = 1 for 12 clocks: q steps 1..9, 0, 1, 2.
  - tc is high only while q = 9; wrap is high in the cycle after q goes 9→0.
- Down-count underflow:
  - Load d = 2, then en = 1, up = 0: q steps 1, 0, 9, 8.
  - tc is high at q = 0; wrap pulses once after 0→9.
- Load priority and clamp:
  - load = 1, en = 1, d = 5: q = 5, tc = 0.
  - load with d = 13: q = 9.
  - en = 0 for 3 clocks: q holds 9.
- Direction flip at boundary:
  - At q = 9 with up = 1, tc = 1. Drop up to 0 before the edge: tc = 0 and q steps to 8, with no wrap.
- Reset mid-count:
  - Assert reset while q = 6, between edges: q = 0 at once.
  - Release with en = 1, up = 1: the first edge gives q = 1.
- Cascade:
  - Two instances, the second with en = tc of the first; run 100 clocks from 0.
  - The pair reads q_hi = 0, q_lo = 0 again (a 00→99 decade rollover).
  - The second stage's wrap pulses exactly once.
